// File: rtl/mult_rr_scheduler.sv
// mult_rr_scheduler: round-robin sharing of one handshaked signed 16x16 multiplier, with watchdog abort
module mult_rr_scheduler #(
  parameter int N_REQ = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [16*N_REQ-1:0] req_arg_a,
  input  logic [N_REQ-1:0]    req_arg_a_parity,
  input  logic [16*N_REQ-1:0] req_arg_b,
  input  logic [N_REQ-1:0]    req_arg_b_parity,
  output logic [N_REQ-1:0]    req_ack,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [31:0]         rsp_result,
  output logic                rsp_result_parity,
  output logic                rsp_parity_error,
  output logic                rsp_timeout,
  output logic                mul_req,
  output logic [15:0]         mul_arg_a,
  output logic [15:0]         mul_arg_b,
  output logic                mul_arg_a_parity,
  output logic                mul_arg_b_parity,
  input  logic                mul_ack,
  input  logic [31:0]         mul_result,
  input  logic                mul_result_parity,
  input  logic                mul_arg_parity_error,
  input  logic                mul_result_rdy
);
  localparam int IW = $clog2(N_REQ);
  localparam int WW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, REL, WAIT_RES, DRAIN} state_t;
  state_t state;
  logic [IW-1:0] ptr, cur, pick;
  logic [WW-1:0] wd;
  logic found, busy, wd_hit;
  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    return IW'(s >= N_REQ ? s - N_REQ : s);
  endfunction
  // scan from the farthest offset down so the nearest valid index at/after ptr wins
  always_comb begin
    pick = '0;
    found = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req_valid[rr_idx(ptr, k)]) begin
        pick = rr_idx(ptr, k);
        found = 1'b1;
      end
  end
  assign busy = state inside {ISSUE, REL, WAIT_RES};
  assign wd_hit = wd == WW'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      cur <= '0;
      wd <= '0;
      req_ack <= '0;
      rsp_valid <= '0;
      rsp_result <= '0;
      rsp_result_parity <= 1'b0;
      rsp_parity_error <= 1'b0;
      rsp_timeout <= 1'b0;
      mul_req <= 1'b0;
      mul_arg_a <= '0;
      mul_arg_b <= '0;
      mul_arg_a_parity <= 1'b0;
      mul_arg_b_parity <= 1'b0;
    end else begin
      req_ack <= '0;
      rsp_valid <= '0;
      rsp_timeout <= 1'b0;
      if (busy && wd_hit) begin
        mul_req <= 1'b0;
        rsp_valid <= N_REQ'(1) << cur;
        rsp_timeout <= 1'b1;
        rsp_result <= '0;
        rsp_result_parity <= 1'b0;
        rsp_parity_error <= 1'b0;
        ptr <= rr_idx(cur, 1);
        wd <= WW'(TIMEOUT);
        state <= DRAIN;
      end else begin
        if (busy) wd <= wd + 1'b1;
        case (state)
          IDLE: if (found) begin
            req_ack <= N_REQ'(1) << pick;
            mul_req <= 1'b1;
            mul_arg_a <= req_arg_a[{pick, 4'b0} +: 16];
            mul_arg_b <= req_arg_b[{pick, 4'b0} +: 16];
            mul_arg_a_parity <= req_arg_a_parity[pick];
            mul_arg_b_parity <= req_arg_b_parity[pick];
            cur <= pick;
            wd <= '0;
            state <= ISSUE;
          end
          ISSUE: if (mul_ack) begin
            mul_req <= 1'b0;
            state <= REL;
          end
          REL: if (!mul_ack) state <= WAIT_RES;
          WAIT_RES: if (mul_result_rdy) begin
            rsp_valid <= N_REQ'(1) << cur;
            rsp_result <= mul_result;
            rsp_result_parity <= mul_result_parity;
            rsp_parity_error <= mul_arg_parity_error;
            ptr <= rr_idx(cur, 1);
            state <= DRAIN;
          end
          DRAIN: if (!mul_result_rdy) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
endmodule

// File: tb/tb_mult_rr_scheduler.sv
// tb_mult_rr_scheduler: table vectors, directed corner sequences and a randomized round-robin model check
module tb_mult_rr_scheduler;
  localparam int N = 4;
  localparam int TO = 20;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req_valid = '0, req_arg_a_parity = '0, req_arg_b_parity = '0;
  logic [16*N-1:0] req_arg_a = '0, req_arg_b = '0;
  logic [N-1:0] req_ack, rsp_valid;
  logic [31:0] rsp_result;
  logic rsp_result_parity, rsp_parity_error, rsp_timeout;
  logic mul_req, mul_arg_a_parity, mul_arg_b_parity;
  logic [15:0] mul_arg_a, mul_arg_b;
  logic mul_ack = 1'b0, mul_result_parity = 1'b0, mul_arg_parity_error = 1'b0, mul_result_rdy = 1'b0;
  logic [31:0] mul_result = '0;
  always #5 clk = ~clk;

  mult_rr_scheduler #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_arg_a(req_arg_a), .req_arg_a_parity(req_arg_a_parity),
    .req_arg_b(req_arg_b), .req_arg_b_parity(req_arg_b_parity),
    .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_result(rsp_result),
    .rsp_result_parity(rsp_result_parity), .rsp_parity_error(rsp_parity_error), .rsp_timeout(rsp_timeout),
    .mul_req(mul_req), .mul_arg_a(mul_arg_a), .mul_arg_b(mul_arg_b),
    .mul_arg_a_parity(mul_arg_a_parity), .mul_arg_b_parity(mul_arg_b_parity),
    .mul_ack(mul_ack), .mul_result(mul_result), .mul_result_parity(mul_result_parity),
    .mul_arg_parity_error(mul_arg_parity_error), .mul_result_rdy(mul_result_rdy)
  );

  // behavioural multiplier: random handshake delays, optional hang, configurable rdy hold
  typedef enum {M_IDLE, M_ACK, M_HOLD, M_CALC, M_RDY} mst_t;
  mst_t mst = M_IDLE;
  int mcnt = 0, mm_hold = 0, rdy_falls = 0;
  logic mm_hang = 1'b0;
  logic [15:0] ma, mb;
  logic mpa, mpb;
  logic signed [31:0] mp;
  always @(negedge clk)
    case (mst)
      M_IDLE: if (mul_req) begin
        ma = mul_arg_a; mb = mul_arg_b; mpa = mul_arg_a_parity; mpb = mul_arg_b_parity;
        mcnt = $urandom_range(0, 2); mst = M_ACK;
      end
      M_ACK: if (mcnt > 0) mcnt--; else begin mul_ack = 1'b1; mcnt = $urandom_range(0, 2); mst = M_HOLD; end
      M_HOLD: if (!mul_req) begin
        if (mcnt > 0) mcnt--; else begin mul_ack = 1'b0; mcnt = $urandom_range(0, 4); mst = M_CALC; end
      end
      M_CALC: if (mul_req) begin
        ma = mul_arg_a; mb = mul_arg_b; mpa = mul_arg_a_parity; mpb = mul_arg_b_parity;
        mcnt = $urandom_range(0, 2); mst = M_ACK;
      end else if (!mm_hang) begin
        if (mcnt > 0) mcnt--;
        else begin
          mp = $signed(ma) * $signed(mb);
          mul_result = mp; mul_result_parity = ^mp;
          mul_arg_parity_error = (^ma != mpa) || (^mb != mpb);
          mul_result_rdy = 1'b1;
          mcnt = mm_hold > 0 ? mm_hold - 1 : $urandom_range(0, 2);
          mst = M_RDY;
        end
      end
      M_RDY: if (mcnt > 0) mcnt--; else begin
        mul_result_rdy = 1'b0; mul_result = $urandom; rdy_falls++; mst = M_IDLE;
      end
      default: mst = M_IDLE;
    endcase

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"}, 32'({req_ack, rsp_valid, rsp_result_parity, rsp_parity_error, rsp_timeout,
                           mul_req, mul_arg_a_parity, mul_arg_b_parity}), 0);
    chk({nm, "_data"}, rsp_result | {mul_arg_a, mul_arg_b}, 0);
  endtask
  task automatic set_req(input int r, input logic [15:0] a, input logic [15:0] b, input logic fa, input logic fb);
    req_arg_a[r*16 +: 16] = a;
    req_arg_b[r*16 +: 16] = b;
    req_arg_a_parity[r] = ^a ^ fa;
    req_arg_b_parity[r] = ^b ^ fb;
    req_valid[r] = 1'b1;
  endtask
  task automatic wait_ack();
    int n = 0;
    do begin @(negedge clk); n++; end while (req_ack == 0 && n < 100);
  endtask
  task automatic wait_rsp();
    int n = 0;
    do begin @(negedge clk); n++; end while (rsp_valid == 0 && n < 200);
  endtask
  task automatic chk_rsp(input string nm, input int r, input logic [31:0] res, input logic err);
    chk({nm, "_rsp"}, 32'(rsp_valid), 32'(1) << r);
    chk({nm, "_result"}, rsp_result, res);
    chk({nm, "_res_par"}, 32'(rsp_result_parity), 32'(^res));
    chk({nm, "_par_err"}, 32'(rsp_parity_error), 32'(err));
    chk({nm, "_timeout"}, 32'(rsp_timeout), 0);
  endtask
  task automatic run_op(input string nm, input int r, input logic [15:0] a, input logic [15:0] b,
                        input logic fa, input logic fb, input logic [31:0] res, input logic err);
    set_req(r, a, b, fa, fb);
    wait_ack();
    mm_hang = 1'b0;
    chk({nm, "_ack"}, 32'(req_ack), 32'(1) << r);
    chk({nm, "_mul_req"}, 32'(mul_req), 1);
    chk({nm, "_args"}, {mul_arg_a, mul_arg_b}, {a, b});
    chk({nm, "_arg_par"}, 32'({mul_arg_a_parity, mul_arg_b_parity}), 32'({^a ^ fa, ^b ^ fb}));
    req_valid[r] = 1'b0;
    wait_rsp();
    chk_rsp(nm, r, res, err);
  endtask
  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  typedef struct {
    int r;
    logic [15:0] a, b;
    logic fa, fb;
    logic [31:0] res;
    logic err;
  } vec_t;
  vec_t tv[8];
  int order[5] = '{0, 1, 2, 3, 0};
  int e, infl, m_ptr, cnt, nrsp, f0, waits[N];
  logic busy_m, got, eerr;
  logic [15:0] ea, eb;
  logic signed [31:0] ep;

  initial begin
    tv[0] = '{0, 16'h0003, 16'hFFFB, 1'b0, 1'b0, 32'hFFFFFFF1, 1'b0};
    tv[1] = '{2, 16'h7FFF, 16'h8000, 1'b0, 1'b0, 32'hC0008000, 1'b0};
    tv[2] = '{2, 16'h7FFF, 16'h8000, 1'b1, 1'b0, 32'hC0008000, 1'b1};
    tv[3] = '{1, 16'h0000, 16'h1234, 1'b0, 1'b0, 32'h00000000, 1'b0};
    tv[4] = '{3, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 32'h00000001, 1'b1};
    tv[5] = '{0, 16'h8000, 16'h8000, 1'b0, 1'b0, 32'h40000000, 1'b0};
    tv[6] = '{1, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 32'h3FFF0001, 1'b0};
    tv[7] = '{3, 16'h0064, 16'hFFFE, 1'b0, 1'b0, 32'hFFFFFF38, 1'b0};
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    // all four at once, then req0 re-requests and must queue behind 1..3
    for (int i = 0; i < N; i++) set_req(i, 16'(i + 2), 16'hFFFD, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      wait_ack();
      chk("rr_grant", 32'(req_ack), 32'(1) << order[k]);
      req_valid[order[k]] = 1'b0;
      wait_rsp();
      chk_rsp("rr", order[k], 32'((order[k] + 2) * -3), 1'b0);
      if (k == 0) req_valid[0] = 1'b1;
    end
    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), tv[i].r, tv[i].a, tv[i].b, tv[i].fa, tv[i].fb, tv[i].res, tv[i].err);
    // result_rdy held 3 cycles with req3 waiting: one response, grant only after rdy falls
    mm_hold = 3;
    set_req(0, 16'd5, 16'd6, 1'b0, 1'b0);
    wait_ack();
    chk("hold_ack0", 32'(req_ack), 1);
    req_valid[0] = 1'b0;
    set_req(3, 16'd7, 16'd8, 1'b0, 1'b0);
    f0 = rdy_falls; nrsp = 0; got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (rsp_valid != 0) begin
        nrsp++;
        chk_rsp("hold", 0, 32'd30, 1'b0);
      end
      if (req_ack != 0) begin
        got = 1'b1;
        chk("hold_ack3", 32'(req_ack), 8);
        chk("hold_after_fall", 32'(rdy_falls - f0), 1);
      end
    end
    chk("hold_one_rsp", 32'(nrsp), 1);
    req_valid[3] = 1'b0;
    wait_rsp();
    chk_rsp("hold3", 3, 32'd56, 1'b0);
    mm_hold = 0;
    // hung multiplier: watchdog aborts exactly TO cycles after the grant
    mm_hang = 1'b1;
    set_req(2, 16'd11, 16'd12, 1'b0, 1'b0);
    wait_ack();
    chk("wd_ack", 32'(req_ack), 4);
    req_valid[2] = 1'b0;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (rsp_valid == 0 && cnt < 100);
    chk("wd_latency", cnt, TO);
    chk("wd_rsp", 32'(rsp_valid), 4);
    chk("wd_timeout", 32'(rsp_timeout), 1);
    chk("wd_fields", {rsp_result[30:0], rsp_result_parity}, 0);
    chk("wd_fields_hi", 32'({rsp_result[31], rsp_parity_error, mul_req}), 0);
    run_op("wd_next", 3, 16'hFFF0, 16'h0010, 1'b0, 1'b0, 32'hFFFFFF00, 1'b0);
    // async reset while waiting for a result: no response, held request re-granted
    mm_hang = 1'b1;
    set_req(1, 16'd9, 16'd9, 1'b0, 1'b0);
    wait_ack();
    chk("ar_ack", 32'(req_ack), 2);
    repeat (12) @(negedge clk);
    chk("ar_in_wait", 32'(mul_req), 0);
    #2 rst_n = 1'b0;
    #1 chk_zero("ar_async");
    @(negedge clk);
    chk_zero("ar_held");
    rst_n = 1'b1;
    nrsp = 0; got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (rsp_valid != 0) nrsp++;
      if (req_ack != 0) got = 1'b1;
    end
    mm_hang = 1'b0;
    chk("ar_regrant", 32'(req_ack), 2);
    chk("ar_no_rsp", 32'(nrsp), 0);
    req_valid[1] = 1'b0;
    wait_rsp();
    chk_rsp("ar_done", 1, 32'd81, 1'b0);
    // randomized traffic against a round-robin reference model
    m_ptr = 2; busy_m = 1'b0; infl = 0;
    for (int i = 0; i < N; i++) waits[i] = 0;
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      if (req_ack != 0) begin
        e = rr_pick(req_valid, m_ptr);
        chk("rnd_grant", 32'(req_ack), e < 0 ? 0 : 32'(1) << e);
        chk("rnd_single", 32'(busy_m), 0);
        if (e >= 0) begin
          chk("rnd_args", {mul_arg_a, mul_arg_b}, {req_arg_a[e*16 +: 16], req_arg_b[e*16 +: 16]});
          chk("rnd_wait_bound", 32'(waits[e] <= N - 1), 1);
          for (int i = 0; i < N; i++) if (i != e && req_valid[i]) waits[i]++;
          ea = req_arg_a[e*16 +: 16]; eb = req_arg_b[e*16 +: 16];
          eerr = (^ea != req_arg_a_parity[e]) || (^eb != req_arg_b_parity[e]);
          infl = e; busy_m = 1'b1; req_valid[e] = 1'b0;
        end
      end
      if (rsp_valid != 0) begin
        ep = $signed(ea) * $signed(eb);
        chk_rsp("rnd", infl, ep, eerr);
        m_ptr = (infl + 1) % N; busy_m = 1'b0;
      end
      if (c < 450)
        for (int i = 0; i < N; i++)
          if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
            set_req(i, 16'($urandom), 16'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
            waits[i] = 0;
          end
    end
    chk("rnd_all_served", 32'({req_valid, busy_m}), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: got no end expected end");
    $fatal(1, "time limit");
  end
endmodule
